// File: rtl/apu_sample_output_stage_if.sv
// Output stream of the APU sample stage: show-ahead head sample with valid/ready handshake.
interface apu_sample_output_stage_if #(
  parameter int unsigned OUT_WIDTH = 8
);
  logic                 valid;
  logic [OUT_WIDTH-1:0] sample;
  logic                 ready;

  modport master (output valid, output sample, input ready);
  modport slave  (input valid, input sample, output ready);
endinterface

// File: rtl/apu_sample_output_stage.sv
// APU sample output stage: box-car decimation, Q2.2 gain with saturation, show-ahead FIFO.
module apu_sample_output_stage #(
  parameter int unsigned IN_WIDTH        = 9,
  parameter int unsigned OUT_WIDTH       = 8,
  parameter int unsigned DECIM_LOG2      = 5,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_sample_valid,
  input  logic [IN_WIDTH-1:0]        i_sample,
  input  logic [3:0]                 i_gain,
  apu_sample_output_stage_if.master  stream,
  output logic [FIFO_DEPTH_LOG2:0]   o_fill,
  output logic                       o_overflow,
  input  logic                       i_clear_overflow
);

  localparam int unsigned ACC_W    = IN_WIDTH + DECIM_LOG2;
  localparam int unsigned CNT_W    = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int unsigned PROD_W   = IN_WIDTH + 4;
  localparam int unsigned SCALED_W = IN_WIDTH + 2;
  localparam int unsigned PTR_W    = FIFO_DEPTH_LOG2;
  localparam int unsigned FILL_W   = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH    = 1 << FIFO_DEPTH_LOG2;

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'((1 << DECIM_LOG2) - 1);
  localparam logic [SCALED_W-1:0] OUT_MAX   = SCALED_W'((64'd1 << OUT_WIDTH) - 64'd1);
  localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0]   FILL_ONE  = FILL_W'(1);

  // Decimating accumulator
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [CNT_W-1:0]    cnt;
  logic                last;
  logic                s1_valid;
  logic [IN_WIDTH-1:0] s1_avg;

  assign sum  = acc + ACC_W'(i_sample);
  // With no decimation cnt is pinned at 0, so every sample is the last one.
  assign last = (cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc      <= '0;
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_avg   <= '0;
    end else begin
      s1_valid <= i_sample_valid && last;
      if (i_sample_valid) begin
        if (last) begin
          acc    <= '0;
          cnt    <= '0;
          s1_avg <= IN_WIDTH'(sum >> DECIM_LOG2);
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Gain and saturation
  logic [PROD_W-1:0]    prod;
  logic [SCALED_W-1:0]  scaled;
  logic [OUT_WIDTH-1:0] sat;
  logic                 s2_valid;
  logic [OUT_WIDTH-1:0] s2_out;

  assign prod   = PROD_W'(s1_avg) * PROD_W'(i_gain);
  assign scaled = SCALED_W'(prod >> 2);
  assign sat    = (scaled > OUT_MAX) ? '1 : scaled[OUT_WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s2_valid <= 1'b0;
      s2_out   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_out   <= sat;
    end
  end

  // Show-ahead FIFO
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     rd_next;
  logic [FILL_W-1:0]    fill;
  logic [OUT_WIDTH-1:0] head;
  logic                 overflow;
  logic                 pop;
  logic                 push;
  logic                 drop;

  assign pop     = (fill != '0) && stream.ready;
  assign push    = s2_valid && ((fill != FILL_FULL) || pop);
  assign drop    = s2_valid && !push;
  assign rd_next = rd_ptr + 1'b1;

  always_ff @(posedge i_clk) begin
    if (!i_reset && push) begin
      mem[wr_ptr] <= s2_out;
    end
  end

  // head is a register rather than mem[rd_ptr] so it keeps the last popped
  // value once the FIFO drains and reads 0 after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      head     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
      if (fill == '0) begin
        if (push) begin
          head <= s2_out;
        end
      end else if (pop) begin
        if (fill == FILL_ONE) begin
          if (push) begin
            head <= s2_out;
          end
        end else begin
          head <= mem[rd_next];
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (i_clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign stream.valid  = (fill != '0);
  assign stream.sample = head;
  assign o_fill        = fill;
  assign o_overflow    = overflow;

endmodule

// File: tb/tb_apu_sample_output_stage.sv
// Directed bench for apu_sample_output_stage: three instances covering D=32, D=2 and D=1.
module tb_apu_sample_output_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] sample;
  logic [3:0] gain;
  logic       clr;
  logic       va, vb, vc;
  logic [4:0] fill_a, fill_b, fill_c;
  logic       ovf_a, ovf_b, ovf_c;

  int unsigned tests = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  apu_sample_output_stage_if #(.OUT_WIDTH(8)) if_a ();
  apu_sample_output_stage_if #(.OUT_WIDTH(8)) if_b ();
  apu_sample_output_stage_if #(.OUT_WIDTH(8)) if_c ();

  apu_sample_output_stage #(.IN_WIDTH(9), .OUT_WIDTH(8), .DECIM_LOG2(5), .FIFO_DEPTH_LOG2(4)) u_d32 (
    .i_clk(clk), .i_reset(rst), .i_sample_valid(va), .i_sample(sample), .i_gain(gain),
    .stream(if_a), .o_fill(fill_a), .o_overflow(ovf_a), .i_clear_overflow(clr));

  apu_sample_output_stage #(.IN_WIDTH(9), .OUT_WIDTH(8), .DECIM_LOG2(1), .FIFO_DEPTH_LOG2(4)) u_d2 (
    .i_clk(clk), .i_reset(rst), .i_sample_valid(vb), .i_sample(sample), .i_gain(gain),
    .stream(if_b), .o_fill(fill_b), .o_overflow(ovf_b), .i_clear_overflow(clr));

  apu_sample_output_stage #(.IN_WIDTH(9), .OUT_WIDTH(8), .DECIM_LOG2(0), .FIFO_DEPTH_LOG2(4)) u_d1 (
    .i_clk(clk), .i_reset(rst), .i_sample_valid(vc), .i_sample(sample), .i_gain(gain),
    .stream(if_c), .o_fill(fill_c), .o_overflow(ovf_c), .i_clear_overflow(clr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_d2(input logic [3:0] g, input logic [31:0] exp, input string tag);
    gain = g;
    sample = 9'd3; vb = 1'b1; tick();
    sample = 9'd4; tick();
    vb = 1'b0; tick(); tick();
    check(tag, if_b.sample, exp);
    check({tag, "_fill"}, fill_b, 1);
    if_b.ready = 1'b1; tick(); if_b.ready = 1'b0;
    check({tag, "_drain"}, fill_b, 0);
  endtask

  initial begin
    rst = 1'b0; sample = '0; gain = 4'd4; clr = 1'b0;
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    if_a.ready = 1'b0; if_b.ready = 1'b0; if_c.ready = 1'b0;

    do_reset();
    check("rst_valid", if_a.valid, 0);
    check("rst_sample", if_a.sample, 0);
    check("rst_fill", fill_a, 0);
    check("rst_ovf", ovf_a, 0);

    // Unity gain average of 32 x 200, with latency from the 32nd capture edge
    gain = 4'd4; sample = 9'd200; va = 1'b1;
    repeat (32) tick();
    va = 1'b0;
    check("lat_e0", if_a.valid, 0);
    tick();
    check("lat_e1", if_a.valid, 0);
    tick();
    check("lat_e2_valid", if_a.valid, 1);
    check("unity_sample", if_a.sample, 200);
    check("unity_fill", fill_a, 1);
    tick();
    check("unity_single", fill_a, 1);
    if_a.ready = 1'b1; tick(); if_a.ready = 1'b0;
    check("pop_valid", if_a.valid, 0);
    check("pop_fill", fill_a, 0);
    check("pop_hold", if_a.sample, 200);
    tick();
    check("empty_ready", fill_a, 0);

    // Reset mid-accumulation discards the partial sum
    sample = 9'd77; va = 1'b1;
    repeat (10) tick();
    rst = 1'b1; tick();
    check("midrst_valid", if_a.valid, 0);
    check("midrst_sample", if_a.sample, 0);
    check("midrst_fill", fill_a, 0);
    check("midrst_ovf", ovf_a, 0);
    rst = 1'b0; sample = 9'd100;
    repeat (32) tick();
    va = 1'b0;
    repeat (3) tick();
    check("midrst_out", if_a.sample, 100);
    check("midrst_one", fill_a, 1);
    repeat (40) tick();
    check("midrst_nostale", fill_a, 1);
    if_a.ready = 1'b1; tick(); if_a.ready = 1'b0;
    check("midrst_drain", fill_a, 0);

    // Saturation and mute
    gain = 4'd15; sample = 9'd300; va = 1'b1;
    repeat (32) tick();
    va = 1'b0; tick(); tick();
    check("sat_valid", if_a.valid, 1);
    check("sat_sample", if_a.sample, 255);
    if_a.ready = 1'b1; tick(); if_a.ready = 1'b0;
    gain = 4'd0; va = 1'b1;
    repeat (32) tick();
    va = 1'b0; tick(); tick();
    check("mute_valid", if_a.valid, 1);
    check("mute_sample", if_a.sample, 0);
    if_a.ready = 1'b1; tick(); if_a.ready = 1'b0;

    // Floor of (3+4)/2 = 3, then gain scaling
    run_d2(4'd4, 3, "floor_g4");
    run_d2(4'd6, 4, "floor_g6");
    run_d2(4'd5, 3, "floor_g5");
    run_d2(4'd15, 11, "floor_g15");

    // FIFO full / overflow with D=1
    do_reset();
    gain = 4'd4; vc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sample = 9'(i);
      tick();
    end
    vc = 1'b0; tick(); tick();
    check("full_fill", fill_c, 16);
    check("full_ovf", ovf_c, 1);
    check("full_head", if_c.sample, 0);
    if_c.ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("pop_order_%0d", i), if_c.sample, i);
      tick();
    end
    if_c.ready = 1'b0;
    check("drain_fill", fill_c, 0);
    check("drain_valid", if_c.valid, 0);
    check("drain_hold", if_c.sample, 15);
    check("drain_ovf_sticky", ovf_c, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    check("clear_ovf", ovf_c, 0);

    // Full with simultaneous read, then drop coinciding with clear
    vc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sample = 9'(100 + i);
      tick();
    end
    vc = 1'b0; tick(); tick();
    check("refill_fill", fill_c, 16);
    check("refill_ovf", ovf_c, 0);
    sample = 9'd50; vc = 1'b1; tick();
    vc = 1'b0; tick();
    if_c.ready = 1'b1; tick(); if_c.ready = 1'b0;
    check("fullrd_fill", fill_c, 16);
    check("fullrd_ovf", ovf_c, 0);
    check("fullrd_head", if_c.sample, 101);
    sample = 9'd60; vc = 1'b1; tick();
    vc = 1'b0; tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("set_beats_clear", ovf_c, 1);
    check("drop_fill", fill_c, 16);
    if_c.ready = 1'b1;
    repeat (15) tick();
    if_c.ready = 1'b0;
    check("fullrd_tail", if_c.sample, 50);
    check("fullrd_tail_fill", fill_c, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
